mfp_ahb_arbiter: RTL

//  Two-master AHB-lite arbiter in front of the mfp_ahb slave fabric (RAMs, GPIO, 7-seg).
//  M0 = MIPS core, M1 = auxiliary master (loader/DMA/Rojobot engine).

---
 rtl/mfp_ahb_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB-lite arbiter in front of the mfp_ahb slave fabric.
// M0 is the MIPS core and M1 is the auxiliary master (loader/DMA/Rojobot).
// One master owns the address phase at a time. The owner of the current
// data phase is tracked separately so that HWDATA follows the transfer and
// not the grant. A master that is not granted is stalled through its own
// HREADY.
// Optional build macro MFP_AHB_ARB_PREEMPT_EN adds forced switching after
// MAX_HOLD accepted transfers. The pre-empted NONSEQ address is parked in a
// per-master replay buffer and is issued first when that master is granted
// again.
module mfp_ahb_arbiter #(
  parameter bit          PARK     = 1'b0,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic        S_HMASTLOCK,
  output logic [31:0] S_HWDATA,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADY
);

  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hmastlock;
  } addr_t;

  addr_t      m_addr [2];
  addr_t      cur;
  addr_t      s_out;
  logic [1:0] req;
  logic [1:0] bufv;
  logic [1:0] wants;
  logic       other;
  logic       owner_idle;
  logic       owner_lock;
  logic       force_sw;
  logic       accept;
  logic       unused_sig;

  logic gnt_q, gnt_d;
  logic downer_q, downer_d;
  logic dvalid_q, dvalid_d;

  assign m_addr[0] = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HMASTLOCK};
  assign m_addr[1] = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HMASTLOCK};
  assign req       = {M1_HTRANS[1], M0_HTRANS[1]};
  assign other     = ~gnt_q;

`ifdef MFP_AHB_ARB_PREEMPT_EN
  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic [1:0]    bufv_q, bufv_d;
  addr_t         buf_q [2];
  addr_t         buf_d [2];
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  assign bufv       = bufv_q;
  assign cur        = bufv_q[gnt_q] ? buf_q[gnt_q] : m_addr[gnt_q];
  // Only a fresh NONSEQ from the live bus is pre-empted; replays, SEQ beats
  // and locked sequences always run to completion.
  assign force_sw   = (MAX_HOLD > 0) && (hold_cnt_q >= HOLD_MAX) && wants[other] &&
                      S_HREADY && !bufv_q[gnt_q] && (m_addr[gnt_q].htrans == 2'b10) &&
                      !m_addr[gnt_q].hmastlock;
  assign unused_sig = dvalid_q;

  // Replay buffer capture/release and the fairness counter.
  always_comb begin
    bufv_d     = bufv_q;
    buf_d      = buf_q;
    hold_cnt_d = hold_cnt_q;
    if (S_HREADY) begin
      if (force_sw) begin
        bufv_d[gnt_q] = 1'b1;
        buf_d[gnt_q]  = m_addr[gnt_q];
      end else if (bufv_q[gnt_q]) begin
        bufv_d[gnt_q] = 1'b0;
      end
      if ((gnt_d != gnt_q) || !wants[other]) begin
        hold_cnt_d = '0;
      end else if (accept && (hold_cnt_q < HOLD_MAX)) begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end
  end

  // Replay buffer and counter registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bufv_q     <= 2'b00;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      hold_cnt_q <= '0;
    end else begin
      bufv_q     <= bufv_d;
      buf_q      <= buf_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign bufv       = 2'b00;
  assign cur        = m_addr[gnt_q];
  assign force_sw   = 1'b0;
  assign unused_sig = ^{dvalid_q, MAX_HOLD};
`endif

  // A buffered master still wants the bus even if its live HTRANS is IDLE.
  assign wants      = req | bufv;
  assign owner_idle = (cur.htrans == 2'b00);
  assign owner_lock = cur.hmastlock;

  // Address-phase mux; a forced switch turns the owner's cycle into IDLE.
  always_comb begin
    s_out = cur;
    if (force_sw) s_out.htrans = 2'b00;
  end

  assign accept      = s_out.htrans[1] & S_HREADY;
  assign S_HADDR     = s_out.haddr;
  assign S_HTRANS    = s_out.htrans;
  assign S_HWRITE    = s_out.hwrite;
  assign S_HSIZE     = s_out.hsize;
  assign S_HMASTLOCK = s_out.hmastlock;

  // Grant and data-phase tracking; everything holds while the fabric stalls.
  always_comb begin
    gnt_d    = gnt_q;
    downer_d = downer_q;
    dvalid_d = dvalid_q;
    if (S_HREADY) begin
      dvalid_d = accept;
      if (accept) downer_d = gnt_q;
      if (force_sw) begin
        gnt_d = other;
      end else if (owner_idle && !owner_lock) begin
        gnt_d = wants[other] ? other : PARK;
      end
    end
  end

  // Grant and data-phase owner registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_q    <= PARK;
      downer_q <= PARK;
      dvalid_q <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      downer_q <= downer_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign M0_HREADY = !gnt_q ? (!bufv[0] & S_HREADY) : !(bufv[0] | req[0]);
  assign M1_HREADY =  gnt_q ? (!bufv[1] & S_HREADY) : !(bufv[1] | req[1]);
  assign S_HWDATA  = downer_q ? M1_HWDATA : M0_HWDATA;
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;

endmodule
